alu_cmd_issuer: RTL

Command front-end that sits directly upstream of the 8-bit ALU and drives its a/b/s/en inputs.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command at a time, holding operands and enable stable for a fixed ALU latency.
- Pulses res_valid with a sequence tag when the ALU's y/carry/zero outputs are ready to capture.

---
 rtl/alu_pkg.sv | 19 +
 rtl/alu_cmd_fifo.sv | 67 ++++++
 rtl/alu_cmd_issuer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared ALU command types: operand/opcode widths, command payload and issuer state.
package alu_pkg;

  localparam int unsigned ALU_W = 8;
  localparam int unsigned OP_W  = 4;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [OP_W-1:0]  op;
  } alu_cmd_t;

  // Also decoded by the downstream result collector.
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } issuer_state_e;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous FIFO with a separate occupancy counter; pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DW-1:0]           wdata,
  input  logic                    pop,
  output logic [DW-1:0]           rdata_c,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full_c,
  output logic                    empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_c  = (count_q == CNT_W'(DEPTH));
  assign empty_c = (count_q == '0);
  assign do_push = push && !full_c && !flush;
  assign do_pop  = pop && !empty_c && !flush;
  assign rdata_c = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (do_push && !do_pop)      count_d = count_q + CNT_W'(1);
      else if (!do_push && do_pop) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Buffers ALU commands and issues them one at a time, holding a/b/s/en for ALU_LAT
// cycles, then pulses res_valid with the command's sequence tag.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned ALU_LAT   = 2,
  parameter logic        EN_ACTIVE = 1'b1,
  parameter int unsigned TAG_W     = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ALU_W-1:0]        cmd_a,
  input  logic [ALU_W-1:0]        cmd_b,
  input  logic [OP_W-1:0]         cmd_op,
  input  logic                    flush,
  output logic [ALU_W-1:0]        alu_a,
  output logic [ALU_W-1:0]        alu_b,
  output logic [ALU_W-1:0]        alu_s,
  output logic                    alu_en,
  output logic                    busy,
  output logic                    res_valid,
  output logic [TAG_W-1:0]        res_tag,
  output logic [$clog2(DEPTH):0]  fifo_count
);

  localparam int unsigned CNT_W   = $clog2(ALU_LAT + 1);
  localparam int unsigned ENTRY_W = $bits(alu_cmd_t) + TAG_W;

  typedef struct packed {
    alu_cmd_t         cmd;
    logic [TAG_W-1:0] tag;
  } entry_t;

  issuer_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ALU_W-1:0] alu_a_q, alu_a_d;
  logic [ALU_W-1:0] alu_b_q, alu_b_d;
  logic [ALU_W-1:0] alu_s_q, alu_s_d;
  logic             alu_en_q, alu_en_d;
  logic             busy_q, busy_d;
  logic             res_valid_q, res_valid_d;
  logic [TAG_W-1:0] res_tag_q, res_tag_d;
  logic [TAG_W-1:0] cur_tag_q, cur_tag_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic               push_c, pop_c, load_c;
  logic               fifo_full_c, fifo_empty_c;
  entry_t             wr_entry, rd_entry;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata_c;

  // A push during flush is discarded, so it must not consume a tag either.
  assign push_c     = cmd_valid && !fifo_full_c && !flush;
  assign cmd_ready  = !fifo_full_c;

  assign wr_entry.cmd.a  = cmd_a;
  assign wr_entry.cmd.b  = cmd_b;
  assign wr_entry.cmd.op = cmd_op;
  assign wr_entry.tag    = tag_q;
  assign fifo_wdata      = wr_entry;
  assign rd_entry        = fifo_rdata_c;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .DW    (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (flush),
    .push    (push_c),
    .wdata   (fifo_wdata),
    .pop     (pop_c),
    .rdata_c (fifo_rdata_c),
    .count   (fifo_count),
    .full_c  (fifo_full_c),
    .empty_c (fifo_empty_c)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_s_d     = alu_s_q;
    alu_en_d    = alu_en_q;
    busy_d      = busy_q;
    res_valid_d = 1'b0;
    res_tag_d   = res_tag_q;
    cur_tag_d   = cur_tag_q;
    tag_d       = tag_q;
    pop_c       = 1'b0;
    load_c      = 1'b0;

    if (push_c) tag_d = tag_q + TAG_W'(1);

    if (flush) begin
      state_d  = IDLE;
      alu_en_d = ~EN_ACTIVE;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty_c) load_c = 1'b1;
        end
        BUSY: begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else begin
            res_valid_d = 1'b1;
            res_tag_d   = cur_tag_q;
            if (!fifo_empty_c) begin
              load_c = 1'b1;
            end else begin
              alu_en_d = ~EN_ACTIVE;
              busy_d   = 1'b0;
              state_d  = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // Issue the FIFO head, either from idle or back-to-back after a result.
      if (load_c) begin
        pop_c     = 1'b1;
        alu_a_d   = rd_entry.cmd.a;
        alu_b_d   = rd_entry.cmd.b;
        alu_s_d   = ALU_W'(rd_entry.cmd.op);
        cur_tag_d = rd_entry.tag;
        alu_en_d  = EN_ACTIVE;
        cnt_d     = CNT_W'(ALU_LAT);
        busy_d    = 1'b1;
        state_d   = BUSY;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_s_q     <= '0;
      alu_en_q    <= ~EN_ACTIVE;
      busy_q      <= 1'b0;
      res_valid_q <= 1'b0;
      res_tag_q   <= '0;
      cur_tag_q   <= '0;
      tag_q       <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_s_q     <= alu_s_d;
      alu_en_q    <= alu_en_d;
      busy_q      <= busy_d;
      res_valid_q <= res_valid_d;
      res_tag_q   <= res_tag_d;
      cur_tag_q   <= cur_tag_d;
      tag_q       <= tag_d;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_s     = alu_s_q;
  assign alu_en    = alu_en_q;
  assign busy      = busy_q;
  assign res_valid = res_valid_q;
  assign res_tag   = res_tag_q;

endmodule
